// File: rtl/vote_tally.sv
// vote_tally: per-candidate saturating vote tally with lock-out, ambiguity rejection and winner scan.
module vote_tally #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic [NUM_CAND-1:0]         validvote,
  input  logic [$clog2(NUM_CAND)-1:0] sel,
  output logic [CNT_W-1:0]            count_out,
  output logic                        vote_ack,
  output logic                        vote_reject,
  output logic [$clog2(NUM_CAND)-1:0] winner,
  output logic                        tie,
  output logic                        winner_valid
);
  localparam int SW = $clog2(NUM_CAND);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic [1:0] {VOTE, LOCK, SCAN, RESULT} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tally_q [NUM_CAND];
  logic [CNT_W-1:0]  tally_d [NUM_CAND];
  logic [LW-1:0]     lock_q, lock_d;
  logic [SW-1:0]     idx_q, idx_d, bidx_q, bidx_d, winner_q, winner_d, vidx;
  logic [CNT_W-1:0]  best_q, best_d, count_q, count_d;
  logic              trun_q, trun_d, tie_q, tie_d, wv_q, wv_d, ack_q, ack_d, rej_q, rej_d;
  logic              any, multi;
  assign any   = |validvote;
  assign multi = (validvote & (validvote - NUM_CAND'(1))) != '0;
  always_comb begin
    vidx = '0;
    for (int k = 0; k < NUM_CAND; k++)
      if (validvote[k]) vidx = SW'(k);
  end
  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    lock_d   = lock_q;
    idx_d    = idx_q;
    best_d   = best_q;
    bidx_d   = bidx_q;
    trun_d   = trun_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    wv_d     = wv_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    count_d  = (int'(sel) < NUM_CAND) ? tally_q[sel] : '0;
    case (state_q)
      VOTE: begin
        if (any && !multi) begin
          tally_d[vidx] = (&tally_q[vidx]) ? tally_q[vidx] : tally_q[vidx] + CNT_W'(1);
          ack_d   = 1'b1;
          state_d = LOCK;
          lock_d  = LW'(LOCK_CYCLES);
        end else if (multi) begin
          rej_d = 1'b1;
        end else if (mode) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      LOCK: begin
        rej_d  = any;
        lock_d = lock_q - LW'(1);
        // window length is fixed; mode only chooses where to go afterwards
        if (lock_q == LW'(1)) begin
          state_d = mode ? SCAN : VOTE;
          idx_d   = '0;
        end
      end
      SCAN: begin
        rej_d = any;
        if (!mode) begin
          state_d = VOTE;
        end else begin
          if (idx_q == '0) begin
            best_d = tally_q[0];
            bidx_d = '0;
            trun_d = 1'b0;
          end else if (tally_q[idx_q] > best_q) begin
            best_d = tally_q[idx_q];
            bidx_d = idx_q;
            trun_d = 1'b0;
          end else if (tally_q[idx_q] == best_q) begin
            trun_d = 1'b1;
          end
          if (idx_q == SW'(NUM_CAND - 1)) begin
            winner_d = bidx_d;
            tie_d    = trun_d;
            wv_d     = 1'b1;
            state_d  = RESULT;
          end else begin
            idx_d = idx_q + SW'(1);
          end
        end
      end
      RESULT: begin
        rej_d = any;
        if (!mode) begin
          state_d = VOTE;
          wv_d    = 1'b0;
        end
      end
      default: state_d = VOTE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= VOTE;
      for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= '0;
      lock_q   <= '0;
      idx_q    <= '0;
      best_q   <= '0;
      bidx_q   <= '0;
      trun_q   <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      wv_q     <= 1'b0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tally_q  <= tally_d;
      lock_q   <= lock_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      bidx_q   <= bidx_d;
      trun_q   <= trun_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      wv_q     <= wv_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      count_q  <= count_d;
    end
  end
  assign count_out    = count_q;
  assign vote_ack     = ack_q;
  assign vote_reject  = rej_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign winner_valid = wv_q;
endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Consumer end of the per-candidate button controllers. It takes their one-cycle validvote pulses, one per candidate, and keeps a saturating tally for each candidate.
- Enforces a lock-out window after each accepted vote and rejects ambiguous simultaneous presses.
- In result mode, a sequential scan finds the winner and flags ties. The per-candidate count is exposed for the display.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 8, width of each tally counter
LOCK_CYCLES, 4, cycles after an accepted vote during which all pulses are rejected (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  reset, asynchronous, active-high
mode  input  1  0 = voting, 1 = result
validvote  input  NUM_CAND  one-cycle vote pulses, bit i = candidate i
sel  input  $clog2(NUM_CAND)  candidate whose tally drives count_out
count_out  output  CNT_W  registered tally of candidate sel
vote_ack  output  1  one-cycle pulse: vote accepted
vote_reject  output  1  one-cycle pulse: vote pulse(s) discarded
winner  output  $clog2(NUM_CAND)  index of highest tally
tie  output  1  another candidate equals the winner's tally
winner_valid  output  1  winner/tie valid (RESULT state)

Behaviour:
Reset:
- rst high at any time, asynchronously: all tallies 0, state VOTE, lock counter 0, scan index 0.
- Outputs during reset: count_out 0, vote_ack 0, vote_reject 0, winner 0, tie 0, winner_valid 0.
- Reset mid-LOCK or mid-SCAN aborts the operation with no residue.

States: VOTE, LOCK, SCAN, RESULT.

VOTE (mode=0), sampled at edge E:
- Exactly one validvote bit i high:
  - tally[i] increments at E, saturating at 2^CNT_W-1; a saturated vote still acks.
  - vote_ack is high for the cycle after E.
  - next state LOCK, lock counter loaded with LOCK_CYCLES.
- Two or more bits high: no tally change; vote_reject is high for the cycle after E; stay in VOTE.
- No bits high: no action.
- mode=1 at E with validvote=0: go to SCAN with idx=0. If validvote is nonzero at the same edge, the vote is processed first and mode is acted on later.

LOCK:
- Lasts exactly LOCK_CYCLES edges; the lock counter decrements each edge.
- Any validvote bit high at a LOCK edge: vote_reject pulse next cycle, no tally change.
- On leaving LOCK: to SCAN if mode=1, otherwise to VOTE.
- A mode change during LOCK never truncates the window.

SCAN:
- One candidate per edge, idx 0..NUM_CAND-1.
- idx 0: best=tally[0], bidx=0, tie=0.
- idx>0:
  - tally[idx] > best: best, bidx updated; tie cleared.
  - tally[idx] == best: tie set.
  - less: no change.
- At the edge processing idx=NUM_CAND-1: winner, tie and winner_valid are registered and the state goes to RESULT. winner_valid therefore rises NUM_CAND edges after the edge that entered SCAN.
- mode=0 at any SCAN edge: abort to VOTE, winner_valid stays 0.
- Any validvote pulse during SCAN is rejected (vote_reject pulse).

RESULT:
- winner/tie held, winner_valid=1.
- validvote pulses are rejected (vote_reject pulse), tallies frozen.
- mode=0: back to VOTE; winner_valid drops at that edge. winner/tie keep their last values but are meaningless.
- Tallies persist across mode changes; they clear only on rst.

General:
- All-zero tallies in SCAN: winner 0, tie 1.
- count_out = tally[sel] registered: 1-cycle latency from a sel change. A tally update at edge E appears on count_out at edge E+1. Active in every state.
- vote_ack and vote_reject are never both high; each is a single-cycle pulse per sampling edge.
- No combinational path from inputs to outputs.

Test Plan:
1. Assert rst mid-run with tallies nonzero and winner_valid=1 -> all outputs 0 immediately (before next clk edge); tallies read 0 via sel after release.
2. mode=0, pulse validvote=4'b0100 at edge E -> vote_ack high cycle E+1, vote_reject 0; sel=2 gives count_out=1 after edge E+1; other tallies 0.
3. Accept vote for candidate 1 at E, pulse candidate 3 at E+2 (LOCK_CYCLES=4) -> vote_reject at E+3, tally[3]=0; pulse candidate 3 at E+5 -> vote_ack, tally[3]=1.
4. validvote=4'b0011 at one edge -> vote_reject one cycle, vote_ack 0, tally[0]=tally[1]=0, state stays VOTE (next single vote accepted without lock delay).
5. 300 separated votes for candidate 0 (CNT_W=8) -> tally[0]=255, every vote acked, no wrap to 0.
6. Tallies {3,6,5,1}, raise mode at E -> winner_valid rises at E+4, winner=1, tie=0. Tallies {3,5,5,1} -> winner=1, tie=1. Drop mode at E+2 -> winner_valid never rises; votes accepted again.
